// File: rtl/pwm_audio_scheduler_pkg.sv
// rtl/pwm_audio_scheduler_pkg.sv - shared types and constants for the PWM audio scheduler
package pwm_audio_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_LOAD  = 2'd2,
        ST_PLAY  = 2'd3
    } state_t;

    // Fill value used when the FIFO runs dry: half of full scale, i.e. 50% duty.
    function automatic int unsigned midscale(input int unsigned width);
        return 32'd1 << (width - 1);
    endfunction

    function automatic int unsigned per_width(input int unsigned periods);
        return (periods > 1) ? $clog2(periods) : 1;
    endfunction

endpackage

// File: rtl/pwm_audio_scheduler_counter.sv
// rtl/pwm_audio_scheduler_counter.sv - PWM phase and period counters with sample boundary strobes
module pwm_audio_counter
    import pwm_audio_scheduler_pkg::*;
#(
    parameter int DATA_WIDTH         = 8,
    parameter int PERIODS_PER_SAMPLE = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  run,
    output logic [DATA_WIDTH-1:0] pwm_cnt,
    output logic                  prefetch_pt,
    output logic                  boundary
);

    localparam int PW = per_width(PERIODS_PER_SAMPLE);
    localparam logic [DATA_WIDTH-1:0] CNT_MAX  = '1;
    localparam logic [DATA_WIDTH-1:0] CNT_PRE  = CNT_MAX - 1'b1;
    localparam logic [PW-1:0]         PER_LAST = PW'(PERIODS_PER_SAMPLE - 1);

    logic [PW-1:0] per_cnt;
    logic          wrap;
    logic          per_last;

    assign per_last    = (per_cnt == PER_LAST);
    assign wrap        = run && (pwm_cnt == CNT_MAX);
    assign boundary    = wrap && per_last;
    // One cycle ahead of the boundary so the FIFO data is ready exactly at the wrap edge.
    assign prefetch_pt = run && per_last && (pwm_cnt == CNT_PRE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt <= '0;
            per_cnt <= '0;
        end else if (clear) begin
            pwm_cnt <= '0;
            per_cnt <= '0;
        end else if (run) begin
            pwm_cnt <= pwm_cnt + 1'b1;
            if (wrap) begin
                per_cnt <= per_last ? '0 : per_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/pwm_audio_scheduler.sv
// rtl/pwm_audio_scheduler.sv - FIFO-fed PWM audio player with gapless prefetch and underrun fill
module pwm_audio_scheduler
    import pwm_audio_scheduler_pkg::*;
#(
    parameter int DATA_WIDTH         = 8,
    parameter int PERIODS_PER_SAMPLE = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_r_en,
    output logic                  pwm_out,
    output logic                  playing,
    output logic                  sample_tick,
    output logic                  underrun,
    output logic [15:0]           underrun_cnt
);

    localparam logic [DATA_WIDTH-1:0] MID = DATA_WIDTH'(midscale(DATA_WIDTH));

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] sample_q;
    logic [DATA_WIDTH-1:0] pwm_cnt;
    logic [15:0]           underrun_cnt_q;
    logic                  pref_q;
    logic                  prefetch_pt;
    logic                  boundary;
    logic                  load_fifo;
    logic                  load_mid;

    pwm_audio_counter #(
        .DATA_WIDTH        (DATA_WIDTH),
        .PERIODS_PER_SAMPLE(PERIODS_PER_SAMPLE)
    ) u_counter (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (state_q == ST_LOAD),
        .run        (state_q == ST_PLAY),
        .pwm_cnt    (pwm_cnt),
        .prefetch_pt(prefetch_pt),
        .boundary   (boundary)
    );

    always_comb begin
        state_d     = state_q;
        fifo_r_en   = 1'b0;
        sample_tick = 1'b0;
        underrun    = 1'b0;
        load_fifo   = 1'b0;
        load_mid    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (enable && !fifo_empty) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                fifo_r_en = 1'b1;
                state_d   = ST_LOAD;
            end
            ST_LOAD: begin
                sample_tick = 1'b1;
                load_fifo   = 1'b1;
                state_d     = ST_PLAY;
            end
            ST_PLAY: begin
                fifo_r_en = prefetch_pt && enable && !fifo_empty;
                // A sample already read must be played even if enable dropped meanwhile.
                if (boundary) begin
                    if (pref_q) begin
                        sample_tick = 1'b1;
                        load_fifo   = 1'b1;
                    end else if (enable) begin
                        sample_tick = 1'b1;
                        underrun    = 1'b1;
                        load_mid    = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            sample_q       <= '0;
            underrun_cnt_q <= '0;
            pref_q         <= 1'b0;
        end else begin
            state_q <= state_d;
            if (load_fifo) begin
                sample_q <= fifo_data;
            end else if (load_mid) begin
                sample_q <= MID;
            end
            if (underrun && (underrun_cnt_q != 16'hFFFF)) begin
                underrun_cnt_q <= underrun_cnt_q + 16'd1;
            end
            if ((state_q != ST_PLAY) || boundary) begin
                pref_q <= 1'b0;
            end else if (fifo_r_en) begin
                pref_q <= 1'b1;
            end
        end
    end

    assign playing      = (state_q == ST_PLAY);
    assign pwm_out      = playing && (pwm_cnt < sample_q);
    assign underrun_cnt = underrun_cnt_q;

endmodule

// File: tb/tb_pwm_audio_scheduler.sv
// tb/tb_pwm_audio_scheduler.sv - directed scoreboard bench for pwm_audio_scheduler
module tb_pwm_audio_scheduler;

    typedef struct packed {
        logic [7:0] d;
        logic       ur;
    } sb_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        fifo_empty;
    logic [7:0]  fifo_data = '0;
    logic        fifo_r_en;
    logic        pwm_out;
    logic        playing;
    logic        sample_tick;
    logic        underrun;
    logic [15:0] underrun_cnt;

    logic [7:0]  mem [0:63];
    int          wr_ptr = 0;
    int          rd_ptr = 0;
    sb_t         sb [$];
    sb_t         item;
    int          vectors = 0;
    int          miscompares = 0;
    bit          act = 0;
    int          phase = 0;
    logic [7:0]  cur = '0;

    pwm_audio_scheduler #(.DATA_WIDTH(8), .PERIODS_PER_SAMPLE(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .fifo_empty  (fifo_empty),
        .fifo_data   (fifo_data),
        .fifo_r_en   (fifo_r_en),
        .pwm_out     (pwm_out),
        .playing     (playing),
        .sample_tick (sample_tick),
        .underrun    (underrun),
        .underrun_cnt(underrun_cnt)
    );

    always #5 clk = ~clk;

    assign fifo_empty = (rd_ptr == wr_ptr);

    always @(posedge clk) begin
        if (fifo_r_en && !fifo_empty) begin
            fifo_data <= mem[rd_ptr % 64];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] d);
        mem[wr_ptr % 64] = d;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic expect_s(input logic [7:0] d, input logic ur);
        sb.push_back('{d: d, ur: ur});
    endtask

    // Reference player: tracks which sample should be on the output and where in it we are.
    always @(negedge clk) begin
        if (!rst_n) begin
            act   = 0;
            phase = 0;
            cur   = '0;
            sb.delete();
        end else begin
            chk("pwm_out", pwm_out, act && ((phase % 256) < cur));
            chk("playing", playing, act);
            chk("ren_when_empty", fifo_r_en & fifo_empty, 0);
            if (act) chk("prefetch", fifo_r_en, (phase == 1022) && !fifo_empty && enable);
            if (sample_tick) begin
                if (act) chk("tick_phase", phase, 1023);
                if (sb.size() == 0) begin
                    chk("sb_underflow", sample_tick, 0);
                end else begin
                    item = sb.pop_front();
                    chk("underrun", underrun, item.ur);
                    cur = item.d;
                end
                act   = 1;
                phase = 0;
            end else begin
                chk("underrun_no_tick", underrun, 0);
                if (act) begin
                    phase++;
                    if (phase == 1024) act = 0;
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n  = 1'b0;
        enable = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_pwm", pwm_out, 0);
        chk("rst_ren", fifo_r_en, 0);
        chk("rst_play", playing, 0);
        chk("rst_tick", sample_tick, 0);
        chk("rst_ur", underrun, 0);
        chk("rst_ucnt", underrun_cnt, 0);
        #1 rst_n = 1'b1;

        @(negedge clk);
        #1;
        push(8'h40); push(8'h10); push(8'hF0);
        expect_s(8'h40, 0); expect_s(8'h10, 0); expect_s(8'hF0, 0); expect_s(8'h80, 1);
        enable = 1'b1;
        @(negedge clk);
        chk("fetch_ren", fifo_r_en, 1);
        chk("fetch_tick", sample_tick, 0);
        @(negedge clk);
        chk("load_tick", sample_tick, 1);
        chk("load_ren", fifo_r_en, 0);

        repeat (3083) @(negedge clk);
        chk("ucnt_one", underrun_cnt, 1);
        #1;
        push(8'h20);
        expect_s(8'h20, 0);

        repeat (1370) @(negedge clk);
        #1 enable = 1'b0;

        repeat (675) @(negedge clk);
        #1 push(8'h60);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("idle_ren", fifo_r_en, 0);
            chk("idle_pwm", pwm_out, 0);
        end
        #1;
        expect_s(8'h60, 0);
        enable = 1'b1;

        repeat (300) @(negedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_pwm", pwm_out, 0);
        chk("arst_ren", fifo_r_en, 0);
        chk("arst_play", playing, 0);
        chk("arst_tick", sample_tick, 0);
        chk("arst_ur", underrun, 0);
        chk("arst_ucnt", underrun_cnt, 0);
        enable = 1'b0;
        wr_ptr = rd_ptr;
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        push(8'h55);
        expect_s(8'h55, 0); expect_s(8'h80, 1);
        enable = 1'b1;
        @(negedge clk);
        chk("rel_ren", fifo_r_en, 1);
        chk("rel_play", playing, 0);
        force dut.underrun_cnt_q = 16'hFFFF;
        @(negedge clk);
        chk("rel_tick", sample_tick, 1);
        release dut.underrun_cnt_q;
        chk("ucnt_forced", underrun_cnt, 16'hFFFF);

        repeat (1025) @(negedge clk);
        chk("ucnt_sat", underrun_cnt, 16'hFFFF);
        #1 enable = 1'b0;

        repeat (1030) @(negedge clk);
        chk("end_play", playing, 0);
        chk("end_pwm", pwm_out, 0);
        chk("sb_drained", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pwm_audio_scheduler.md
PWM_AUDIO_SCHEDULER -- requirements
Module: pwm_audio_scheduler

Interface
REQ-001 Parameter DATA_WIDTH, 8: sample width; PWM period = 2^DATA_WIDTH clk cycles.
REQ-002 Parameter PERIODS_PER_SAMPLE, 4: PWM periods each sample is held for (>=1).
REQ-003 Port clk  input  1  single clock; all state on rising edge.
REQ-004 Port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 Port enable  input  1  playback request, level-sensitive.
REQ-006 Port fifo_empty  input  1  sample FIFO empty flag.
REQ-007 Port fifo_data  input  DATA_WIDTH  FIFO read data, valid the cycle after a read strobe.
REQ-008 Port fifo_r_en  output  1  single-cycle FIFO read strobe.
REQ-009 Port pwm_out  output  1  PWM audio output.
REQ-010 Port playing  output  1  high in PLAY state.
REQ-011 Port sample_tick  output  1  one-cycle pulse on every sample_q load, including fill loads.
REQ-012 Port underrun  output  1  one-cycle pulse when a midscale fill replaces a missing sample.
REQ-013 Port underrun_cnt  output  16  saturating count of underruns since reset.

Function
REQ-014 FSM states IDLE, FETCH, LOAD, PLAY; registers pwm_cnt (DATA_WIDTH bits), per_cnt (clog2 of PERIODS_PER_SAMPLE bits, min 1), sample_q (DATA_WIDTH bits).
REQ-015 IDLE: pwm_out=0, fifo_r_en=0; go to FETCH when enable=1 and fifo_empty=0; otherwise stay.
REQ-016 FETCH: fifo_r_en=1 for exactly one cycle; unconditionally go to LOAD.
REQ-017 LOAD: sample_q <= fifo_data, pwm_cnt <= 0, per_cnt <= 0, sample_tick=1; go to PLAY.
REQ-018 PLAY: pwm_cnt increments every cycle, wrapping 2^DATA_WIDTH-1 -> 0; per_cnt increments on each pwm_cnt wrap, wrapping PERIODS_PER_SAMPLE-1 -> 0.
REQ-019 pwm_out = (state==PLAY) and (pwm_cnt < sample_q), unsigned compare; sample 0 gives constant low, 2^DATA_WIDTH-1 gives high for all but one cycle per period.
REQ-020 Prefetch: in PLAY with per_cnt==PERIODS_PER_SAMPLE-1 and pwm_cnt==2^DATA_WIDTH-2, assert fifo_r_en iff fifo_empty=0 and enable=1.
REQ-021 Sample boundary (per_cnt last, pwm_cnt max): if prefetch issued, sample_q <= fifo_data at the wrap edge with sample_tick=1, so there is zero gap between samples.
REQ-022 Boundary with enable=1 and no prefetch (FIFO empty): sample_q <= 2^(DATA_WIDTH-1) (midscale), sample_tick=1, underrun=1, underrun_cnt+1 saturating at 16'hFFFF; remain in PLAY.
REQ-023 Boundary with enable=0: go to IDLE, no fill, no underrun; the current sample always completes.
REQ-024 enable falling mid-sample has no effect until the boundary; enable rising in PLAY has no effect.
REQ-025 fifo_r_en is never asserted while fifo_empty=1, and is asserted at most once per sample.
REQ-026 underrun and sample_tick in the same cycle are legal; underrun implies sample_tick.

Reset
REQ-027 rst_n=0 immediately forces IDLE, pwm_cnt=0, per_cnt=0, sample_q=0, underrun_cnt=0; all outputs 0.
REQ-028 Reset mid-PLAY or mid-FETCH aborts with no pending read; the first cycle after release is IDLE.

Structure
REQ-029 Shared package holds the state enumeration and the midscale constant function of DATA_WIDTH.
REQ-030 One sub-module, pwm_audio_counter, holds pwm_cnt, per_cnt and the wrap/prefetch/boundary strobes; the FSM, sample register and compare stay in the top level.

Verification
REQ-031 DATA_WIDTH=8, P=4, FIFO preloaded with 0x40, enable=1: fifo_r_en 1 cycle after enable, sample_tick 2 cycles after it, pwm_out high 64 of every 256 cycles for 1024 cycles.
REQ-032 FIFO holds 0x10, 0xF0: second sample takes effect exactly at cycle 1024 of PLAY with no gap; fifo_r_en seen at pwm_cnt=254 of period 3.
REQ-033 FIFO drained after one sample, enable held: at the boundary underrun=1, sample_q=0x80, underrun_cnt=1, 50% duty; refill resumes normal loads at the next boundary.
REQ-034 enable dropped at pwm_cnt=100 of period 1: output continues to the boundary, then IDLE with pwm_out=0 and no read strobe.
REQ-035 rst_n pulsed low mid-PLAY: all outputs 0 asynchronously, underrun_cnt=0, the FSM restarts from IDLE.
REQ-036 Force underrun_cnt to 16'hFFFF and cause one more underrun: the count stays at FFFF and underrun still pulses.
